// File: rtl/cpu_pkg.sv
// cpu_pkg: shared owner tags, arbiter halt states and default bus widths.
package cpu_pkg;
  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_LS, OWN_DBG} owner_t;
  // HALTED is the only state with bit 1 set, so halted comes straight off a flop.
  typedef enum logic [1:0] {
    ARB_RUN    = 2'b00,
    ARB_DRAIN  = 2'b01,
    ARB_HALTED = 2'b10
  } arb_state_t;
endpackage

// File: rtl/mem_arb_tagpipe.sv
// mem_arb_tagpipe: MEM_LAT-deep owner-tag shift register; head names the owner of mem_rdata.
// any_read is registered: it flags reads that will sit behind the head in the next cycle.
module mem_arb_tagpipe
  import cpu_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic   clk,
  input  logic   rst,
  input  owner_t tag_in,
  output owner_t head,
  output logic   any_read
);
  owner_t pipe [MEM_LAT];
  logic queued;
  always_comb begin
    queued = MEM_LAT > 1 && tag_in != OWN_NONE;
    for (int i = 0; i < MEM_LAT - 2; i++) queued = queued || pipe[i] != OWN_NONE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MEM_LAT; i++) pipe[i] <= OWN_NONE;
      any_read <= 1'b0;
    end else begin
      pipe[0] <= tag_in;
      for (int i = 1; i < MEM_LAT; i++) pipe[i] <= pipe[i-1];
      any_read <= queued;
    end
  end
  assign head = pipe[MEM_LAT-1];
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch, load/store and (with ARB_DBG_PORT_EN) a debug port.
// Debug port, dbg_halt, halted and the halt FSM exist only when ARB_DBG_PORT_EN is defined.
module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
`ifdef ARB_DBG_PORT_EN
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  input  logic              dbg_halt,
  output logic              halted,
`endif
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  arb_state_t state;
  owner_t cmd_tag, head, gnt_tag;
  logic [SW-1:0] starve;
  logic [ADDR_W-1:0] gnt_addr;
  logic [DATA_W-1:0] gnt_wdata;
  logic run, starved, drained, any_read, any_gnt, gnt_we, halt_req;

`ifdef ARB_DBG_PORT_EN
  assign halt_req   = dbg_halt;
  assign halted     = state[1];
  assign dbg_gnt    = dbg_req && (state == ARB_HALTED || run && !ls_req && !starved);
  assign dbg_rvalid = head == OWN_DBG;
  assign dbg_rdata  = mem_rdata;
`else
  logic dbg_req, dbg_gnt, dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  assign halt_req  = 1'b0;
  assign dbg_req   = 1'b0;
  assign dbg_gnt   = 1'b0;
  assign dbg_we    = 1'b0;
  assign dbg_addr  = '0;
  assign dbg_wdata = '0;
`endif

  assign run     = state == ARB_RUN;
  assign starved = if_req && starve == SW'(STARVE_MAX);
  // The command stage still counts as in flight until it has entered the tag pipe.
  assign drained = cmd_tag == OWN_NONE && !any_read;

  assign if_gnt = run && if_req && (starved || !ls_req && !dbg_req);
  assign ls_gnt = run && ls_req && !starved;

  assign any_gnt   = if_gnt || ls_gnt || dbg_gnt;
  assign gnt_addr  = ls_gnt ? ls_addr : dbg_gnt ? dbg_addr : if_addr;
  assign gnt_wdata = ls_gnt ? ls_wdata : dbg_gnt ? dbg_wdata : mem_wdata;
  assign gnt_we    = ls_gnt ? ls_we : dbg_gnt && dbg_we;
  assign gnt_tag   = !any_gnt || gnt_we ? OWN_NONE : ls_gnt ? OWN_LS : dbg_gnt ? OWN_DBG : OWN_IF;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      cmd_tag   <= OWN_NONE;
      starve    <= '0;
    end else begin
      if (any_gnt) begin
        mem_addr  <= gnt_addr;
        mem_wdata <= gnt_wdata;
      end
      mem_we  <= any_gnt && gnt_we;
      mem_re  <= any_gnt && !gnt_we;
      cmd_tag <= gnt_tag;
      starve  <= !run || !if_req || if_gnt ? '0 : starved ? starve : starve + SW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ARB_RUN;
    else case (state)
      ARB_RUN:   state <= halt_req ? ARB_DRAIN : ARB_RUN;
      ARB_DRAIN: state <= !halt_req ? ARB_RUN : drained ? ARB_HALTED : ARB_DRAIN;
      default:   state <= halt_req ? ARB_HALTED : ARB_RUN;
    endcase
  end

  mem_arb_tagpipe #(.MEM_LAT(MEM_LAT)) u_tagpipe (
    .clk      (clk),
    .rst      (rst),
    .tag_in   (cmd_tag),
    .head     (head),
    .any_read (any_read)
  );

  assign if_rvalid = head == OWN_IF;
  assign ls_rvalid = head == OWN_LS;
  assign if_rdata  = mem_rdata;
  assign ls_rdata  = mem_rdata;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus with a read-response scoreboard; one DUT at MEM_LAT=1, one at MEM_LAT=2.
module tb_mem_port_arbiter;
  typedef struct {logic [15:0] d; int due;} exp_t;
  logic clk = 1'b0, rst = 1'b1;
  int cyc = 0, checks = 0, errs = 0, t0 = 0;
  exp_t q_if[$], q_ls[$], q_dbg[$], q_p[$];
  logic if_req = 0, ls_req = 0, ls_we = 0;
  logic [15:0] if_addr = 0, ls_addr = 0, ls_wdata = 0;
  logic if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_we, mem_re;
  logic [15:0] if_rdata, ls_rdata, mem_addr, mem_wdata, mem_rdata;
  logic p_if_req = 0, p_zero = 0;
  logic [15:0] p_if_addr = 0, p_zero_w = 0;
  logic p_if_gnt, p_if_rvalid, p_ls_gnt, p_ls_rvalid, p_mem_we, p_mem_re;
  logic [15:0] p_if_rdata, p_ls_rdata, p_mem_addr, p_mem_wdata, p_mem_rdata;
`ifdef ARB_DBG_PORT_EN
  logic dbg_req = 0, dbg_we = 0, dbg_halt = 0, dbg_gnt, dbg_rvalid, halted;
  logic [15:0] dbg_addr = 0, dbg_wdata = 0, dbg_rdata;
  logic p_dbg_gnt, p_dbg_rvalid, p_halted;
  logic [15:0] p_dbg_rdata;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter #(.MEM_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
`ifdef ARB_DBG_PORT_EN
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .dbg_halt(dbg_halt), .halted(halted),
`endif
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.MEM_LAT(2)) dut2 (
    .clk(clk), .rst(rst),
    .if_req(p_if_req), .if_addr(p_if_addr), .if_gnt(p_if_gnt), .if_rvalid(p_if_rvalid), .if_rdata(p_if_rdata),
    .ls_req(p_zero), .ls_we(p_zero), .ls_addr(p_zero_w), .ls_wdata(p_zero_w),
    .ls_gnt(p_ls_gnt), .ls_rvalid(p_ls_rvalid), .ls_rdata(p_ls_rdata),
`ifdef ARB_DBG_PORT_EN
    .dbg_req(p_zero), .dbg_we(p_zero), .dbg_addr(p_zero_w), .dbg_wdata(p_zero_w),
    .dbg_gnt(p_dbg_gnt), .dbg_rvalid(p_dbg_rvalid), .dbg_rdata(p_dbg_rdata),
    .dbg_halt(p_zero), .halted(p_halted),
`endif
    .mem_addr(p_mem_addr), .mem_wdata(p_mem_wdata), .mem_we(p_mem_we), .mem_re(p_mem_re), .mem_rdata(p_mem_rdata)
  );

  function automatic logic [15:0] iv(input logic [15:0] a);
    return a ^ 16'hC35A;
  endfunction

  // Memory models: unwritten words read as iv(addr); latency 1 for dut, 2 for dut2.
  logic [15:0] m1 [4096];
  logic w1 [4096];
  logic [15:0] rd1 = 0, p2a = 0, p2b = 0;
  assign mem_rdata = rd1;
  assign p_mem_rdata = p2b;
  always @(posedge clk) begin
    if (rst) for (int i = 0; i < 4096; i++) w1[i] <= 1'b0;
    else if (mem_we) begin
      m1[mem_addr[11:0]] <= mem_wdata;
      w1[mem_addr[11:0]] <= 1'b1;
    end
    if (mem_re) rd1 <= w1[mem_addr[11:0]] ? m1[mem_addr[11:0]] : iv(mem_addr);
    if (p_mem_re) p2a <= iv(p_mem_addr);
    p2b <= p2a;
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", n, a, e, cyc);
    end
  endtask

  task automatic got(input string n, input bit emp, input exp_t e, input logic [15:0] d);
    if (emp) begin
      checks++;
      errs++;
      $display("FAIL %s: unexpected rvalid at cycle %0d data %0h, expected none", n, cyc, d);
    end else begin
      chk({n, " data"}, {16'h0, d}, {16'h0, e.d});
      chk({n, " cycle"}, cyc, e.due);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    bit emp;
    if (!rst) begin
      if (if_rvalid) begin
        emp = q_if.size() == 0;
        if (!emp) e = q_if.pop_front();
        got("if_rvalid", emp, e, if_rdata);
      end
      if (ls_rvalid) begin
        emp = q_ls.size() == 0;
        if (!emp) e = q_ls.pop_front();
        got("ls_rvalid", emp, e, ls_rdata);
      end
`ifdef ARB_DBG_PORT_EN
      if (dbg_rvalid) begin
        emp = q_dbg.size() == 0;
        if (!emp) e = q_dbg.pop_front();
        got("dbg_rvalid", emp, e, dbg_rdata);
      end
`endif
      if (p_if_rvalid) begin
        emp = q_p.size() == 0;
        if (!emp) e = q_p.pop_front();
        got("lat2 if_rvalid", emp, e, p_if_rdata);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst mem_re", mem_re, 0);
    chk("rst mem_we", mem_we, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst mem_wdata", mem_wdata, 0);
    tick;
    rst = 0;
    @(negedge clk);
    chk("post-rst ls_rvalid", ls_rvalid, 0);
    chk("post-rst if_rvalid", if_rvalid, 0);
`ifdef ARB_DBG_PORT_EN
    chk("post-rst halted", halted, 0);
`endif
    // first fetch is granted combinationally
    tick; t0 = cyc;
    if_req = 1; if_addr = 16'h0000;
    @(negedge clk);
    chk("first if_gnt", if_gnt, 1);
    q_if.push_back('{iv(16'h0000), t0 + 2});
    tick; if_req = 0;
    @(negedge clk);
    chk("first mem_re", mem_re, 1);
    chk("first mem_addr", mem_addr, 16'h0000);
    repeat (3) tick;
    // conflict: ls wins, fetch follows
    t0 = cyc;
    if_req = 1; if_addr = 16'h0010;
    ls_req = 1; ls_we = 0; ls_addr = 16'h0200;
    @(negedge clk);
    chk("conflict ls_gnt c0", ls_gnt, 1);
    chk("conflict if_gnt c0", if_gnt, 0);
    q_ls.push_back('{iv(16'h0200), t0 + 2});
    tick; ls_req = 0;
    @(negedge clk);
    chk("conflict if_gnt c1", if_gnt, 1);
    chk("conflict mem_addr c1", mem_addr, 16'h0200);
    chk("conflict mem_re c1", mem_re, 1);
    q_if.push_back('{iv(16'h0010), t0 + 3});
    tick; if_req = 0;
    @(negedge clk);
    chk("conflict mem_addr c2", mem_addr, 16'h0010);
    repeat (3) tick;
    // starvation: fetch forced through after STARVE_MAX denied cycles
    t0 = cyc;
    ls_req = 1; ls_we = 0; ls_addr = 16'h0300;
    if_req = 1; if_addr = 16'h0020;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) if_addr = 16'h0021;
      @(negedge clk);
      chk($sformatf("starve ls_gnt c%0d", i), ls_gnt, (i != 4) ? 1 : 0);
      chk($sformatf("starve if_gnt c%0d", i), if_gnt, (i == 4) ? 1 : 0);
      if (i != 4) q_ls.push_back('{iv(16'h0300), t0 + i + 2});
      else q_if.push_back('{iv(16'h0020), t0 + 6});
      tick;
    end
    ls_req = 0;
    @(negedge clk);
    chk("starve if_gnt c6", if_gnt, 1);
    q_if.push_back('{iv(16'h0021), t0 + 8});
    tick; if_req = 0;
    repeat (3) tick;
    // read-after-write through ls
    t0 = cyc;
    ls_req = 1; ls_we = 1; ls_addr = 16'h0040; ls_wdata = 16'h1234;
    @(negedge clk);
    chk("raw write gnt", ls_gnt, 1);
    tick; ls_we = 0;
    @(negedge clk);
    chk("raw read gnt", ls_gnt, 1);
    chk("raw mem_we", mem_we, 1);
    chk("raw mem_re", mem_re, 0);
    chk("raw mem_wdata", mem_wdata, 16'h1234);
    q_ls.push_back('{16'h1234, t0 + 3});
    tick; ls_req = 0;
    repeat (3) tick;
`ifdef ARB_DBG_PORT_EN
    // halt: drain ls read, then debug owns memory
    t0 = cyc;
    ls_req = 1; ls_we = 0; ls_addr = 16'h0200;
    @(negedge clk);
    chk("halt ls_gnt", ls_gnt, 1);
    q_ls.push_back('{iv(16'h0200), t0 + 2});
    tick; ls_req = 0; dbg_halt = 1;
    @(negedge clk);
    chk("halt c1 halted", halted, 0);
    tick; if_req = 1; if_addr = 16'h0030;
    @(negedge clk);
    chk("drain if_gnt", if_gnt, 0);
    chk("drain halted", halted, 0);
    tick; dbg_req = 1; dbg_we = 1; dbg_addr = 16'h0005; dbg_wdata = 16'h5A5A;
    @(negedge clk);
    chk("halted c3", halted, 1);
    chk("halted dbg write gnt", dbg_gnt, 1);
    chk("halted if_gnt c3", if_gnt, 0);
    tick; dbg_we = 0;
    @(negedge clk);
    chk("halted dbg read gnt", dbg_gnt, 1);
    chk("halted mem_we", mem_we, 1);
    chk("halted mem_wdata", mem_wdata, 16'h5A5A);
    q_dbg.push_back('{16'h5A5A, t0 + 6});
    tick; dbg_req = 0;
    @(negedge clk);
    chk("halted if_gnt c5", if_gnt, 0);
    tick;
    tick; dbg_halt = 0;
    @(negedge clk);
    chk("unhalt c7 halted", halted, 1);
    chk("unhalt c7 if_gnt", if_gnt, 0);
    tick;
    @(negedge clk);
    chk("unhalt c8 halted", halted, 0);
    chk("unhalt c8 if_gnt", if_gnt, 1);
    q_if.push_back('{iv(16'h0030), t0 + 10});
    tick; if_req = 0;
    repeat (3) tick;
`endif
    // reset mid-operation drops the in-flight read
    ls_req = 1; ls_we = 0; ls_addr = 16'h0200;
    @(negedge clk);
    chk("midrst ls_gnt", ls_gnt, 1);
    tick; ls_req = 0;
    @(negedge clk);
    chk("midrst mem_re before", mem_re, 1);
    rst = 1;
    #1;
    chk("midrst mem_re async", mem_re, 0);
    tick; rst = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("midrst ls_rvalid", ls_rvalid, 0);
      chk("midrst mem_re", mem_re, 0);
      tick;
    end
    // MEM_LAT=2 back-to-back fetches
    t0 = cyc;
    for (int i = 0; i < 3; i++) begin
      p_if_req = 1; p_if_addr = 16'h0100 + 16'(i);
      @(negedge clk);
      chk($sformatf("lat2 if_gnt c%0d", i), p_if_gnt, 1);
      q_p.push_back('{iv(16'h0100 + 16'(i)), t0 + i + 3});
      tick;
    end
    p_if_req = 0;
    repeat (6) tick;
    chk("if pending", q_if.size(), 0);
    chk("ls pending", q_ls.size(), 0);
    chk("dbg pending", q_dbg.size(), 0);
    chk("lat2 pending", q_p.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the CPU's single-port memory between instruction fetch, load/store data access and a debug/DMA port. It issues at most one memory transaction per cycle and routes read data back to the owning requester after the memory's fixed read latency. A halt state machine lets the debug port drain the CPU side and take exclusive ownership of memory. It sits between the CPU core's fetch and load/store paths and the `memory` instance, replacing the ad-hoc address multiplexer.

## Interface
- ADDR_W, 16, address width
- DATA_W, 16, data width
- MEM_LAT, 1, memory read latency in cycles from registered address to `mem_rdata` valid (1..4)
- STARVE_MAX, 4, consecutive denied fetch-request cycles before fetch is forced to top priority
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- if_req / if_addr / if_gnt / if_rvalid / if_rdata  in/in/out/out/out  1/ADDR_W/1/1/DATA_W  fetch port (read-only)
- ls_req / ls_we / ls_addr / ls_wdata / ls_gnt / ls_rvalid / ls_rdata  in/in/in/in/out/out/out  1/1/ADDR_W/DATA_W/1/1/DATA_W  load/store port
- dbg_req / dbg_we / dbg_addr / dbg_wdata / dbg_gnt / dbg_rvalid / dbg_rdata  same directions and widths as ls_*  debug port
- dbg_halt  in  1  level request to halt CPU-side access
- halted  out  1  CPU side drained and blocked
- mem_addr / mem_wdata / mem_we / mem_re  out  ADDR_W/DATA_W/1/1  registered memory command
- mem_rdata  in  DATA_W  memory read data

## Operation
- Handshake: requester holds req and its fields stable until `*_gnt`=1. `*_gnt` is combinational from req and state; at most one gnt is high per cycle. Transfer happens in the cycle gnt=1.
- Priority in RUN: fetch if starve counter == STARVE_MAX, otherwise ls > dbg > fetch.
- Starve counter: increments (saturating at STARVE_MAX) each cycle with if_req=1 and if_gnt=0. Clears on if_gnt, on if_req=0, and outside RUN.
- Granted read: pushes an owner tag (NONE/IF/LS/DBG) into a MEM_LAT-deep tag pipe. Writes and idle cycles push NONE. Writes produce no rvalid.
- Halt FSM states RUN, DRAIN, HALTED:
  - RUN→DRAIN when dbg_halt=1.
  - In DRAIN no grants are given to any port. DRAIN→HALTED when the tag pipe holds no read tags. DRAIN→RUN if dbg_halt falls first.
  - In HALTED `halted`=1 and only the debug port is granted. HALTED→RUN when dbg_halt=0; `halted` falls in the same cycle the state leaves.
- Memory ordering is strict issue order. Read-after-write to the same address returns the new data.

## Timing
- Grant in cycle N: mem_addr, mem_wdata, mem_we and mem_re are valid in cycle N+1. Cycles without a grant drive mem_we=mem_re=0; mem_addr and mem_wdata hold their previous values.
- Read granted in cycle N: the owner's `*_rvalid`=1 with `*_rdata`=mem_rdata in cycle N+1+MEM_LAT, combinational from the tag pipe head. A new grant is allowed every cycle, so full throughput is one transaction per cycle.
- `*_rdata` mirrors mem_rdata at all times; it is meaningful only when `*_rvalid`=1.
- Reset values: all gnt/rvalid=0, mem_we=mem_re=0, mem_addr=0, mem_wdata=0, halted=0, state RUN, starve counter 0, tag pipe all NONE.
- Reset mid-operation clears the tag pipe, so in-flight reads never deliver rvalid. Requesters must reissue.
- dbg_halt rising in the same cycle as a ls or fetch grant: that grant still completes, and its read tag is drained before HALTED.

## Configuration
- ARB_DBG_PORT_EN defined: debug port, dbg_halt, halted and the halt FSM are present as described.
- ARB_DBG_PORT_EN undefined:
  - dbg_* ports, dbg_halt and halted are removed.
  - The FSM is permanently RUN.
  - Priority is fetch when starved, otherwise ls > fetch.

## Structure
- Shared package `cpu_pkg` holds:
  - owner enum OWN_NONE/OWN_IF/OWN_LS/OWN_DBG (2 bits)
  - halt state enum ARB_RUN/ARB_DRAIN/ARB_HALTED
  - default ADDR_W/DATA_W constants
- Sub-module `mem_arb_tagpipe`: MEM_LAT-deep owner-tag shift register with a synchronous `any_read` status output and asynchronous clear.

## Test plan
- Reset: hold rst, then release → all outputs 0, halted=0. The first if_req to 0x0000 gets if_gnt in the same cycle.
- Conflict (MEM_LAT=1): if_req to 0x0010 and ls read of 0x0200 in cycle 0 →
  - ls_gnt in cycle 0; mem_addr=0x0200 with mem_re=1 in cycle 1; ls_rvalid in cycle 2.
  - if_gnt in cycle 1; if_rvalid in cycle 3.
- Starvation: ls_req and if_req both held continuously from cycle 0 → if_gnt in cycle 4 (STARVE_MAX=4), ls_gnt in cycles 0–3 and 5.
- Pipelining (MEM_LAT=2): fetches to 0x0100, 0x0101, 0x0102 granted in cycles 0–2 → if_rvalid in cycles 3–5 with data in order.
- Halt: ls read granted in cycle 0, dbg_halt=1 from cycle 1 →
  - ls_rvalid in cycle 2, halted=1 from cycle 3.
  - if_req gets no grant while halted; a dbg write of 0x5A5A to 0x0005 is granted, and a dbg read of 0x0005 returns 0x5A5A.
  - dbg_halt=0 → halted=0 and fetch resumes.
- Reset mid-operation: ls read granted in cycle 0, rst pulsed in cycle 1 → no ls_rvalid ever, and mem_re=0 after reset.
